// File: rtl/cpc_video_fetch_if.sv
// rtl/cpc_video_fetch_if.sv - video RAM read port (request/acknowledge)
interface cpc_video_fetch_if;
    logic        ram_req;
    logic [15:0] ram_addr;
    logic        ram_ack;
    logic [7:0]  ram_data;

    modport master (
        output ram_req,
        output ram_addr,
        input  ram_ack,
        input  ram_data
    );

    modport slave (
        input  ram_req,
        input  ram_addr,
        output ram_ack,
        output ram_data
    );
endinterface

// File: rtl/cpc_video_fetch.sv
// rtl/cpc_video_fetch.sv - CPC video byte fetch, pixel decode and sync shaping
module cpc_video_fetch (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              clken_i,
    input  logic [13:0]       ma_i,
    input  logic [4:0]        ra_i,
    input  logic              de_i,
    input  logic              hsync_i,
    input  logic              vsync_i,
    input  logic [1:0]        mode_i,
    cpc_video_fetch_if.master ram,
    output logic [3:0]        pix_idx_o,
    output logic              pix_border_o,
    output logic              hs_out_o,
    output logic              vs_out_o,
    output logic              late_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_GAP  = 3'd1,
        S_REQ0 = 3'd2,
        S_REQ1 = 3'd3,
        S_DONE = 3'd4
    } fetch_state_t;

    fetch_state_t state_q, state_d;

    // fetch stage: character sampled at the last CLKEN
    logic [14:0] f_addr_q;
    logic        f_de_q, f_hs_q, f_vs_q;
    logic [1:0]  mode_lat_q;

    // bytes captured during the current fetch window
    logic [7:0]  fb0_q, fb1_q;

    // bytes and lateness presented to the display load on CLKEN
    logic [7:0]  ld_b0, ld_b1;
    logic        win_late;

    // display stage
    logic [15:0] sr_q;
    logic [3:0]  phase_q;
    logic [1:0]  d_mode_q;
    logic        d_de_q, d_hs_q, d_vs_q;
    logic        pix_end;
    logic [7:0]  pix_byte;

    // sync shaping
    logic [2:0]  hs_run_q, hs_run_d;
    logic        hs_out_q, hs_out_d;
    logic        vs_out_q, vs_out_d;
    logic [1:0]  vs_falls_q, vs_falls_d;
    logic        late_q;

    // MA[11:10] and RA[4:3] do not take part in the video address
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, ma_i[11:10], ra_i[4:3]};

    // Fetch FSM state register; reset wins over CLKEN
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Fetch FSM next state: CLKEN always restarts the window through GAP
    always_comb begin
        state_d = state_q;
        if (clken_i) begin
            state_d = S_GAP;
        end else begin
            case (state_q)
                S_GAP:   state_d = S_REQ0;
                S_REQ0:  if (ram.ram_ack) state_d = S_REQ1;
                S_REQ1:  if (ram.ram_ack) state_d = S_DONE;
                default: state_d = state_q;
            endcase
        end
    end

    // Fetch FSM outputs: request held with a stable address until acked
    always_comb begin
        ram.ram_req  = 1'b0;
        ram.ram_addr = 16'h0000;
        case (state_q)
            S_REQ0: begin
                ram.ram_req  = 1'b1;
                ram.ram_addr = {f_addr_q, 1'b0};
            end
            S_REQ1: begin
                ram.ram_req  = 1'b1;
                ram.ram_addr = {f_addr_q, 1'b1};
            end
            default: begin
                ram.ram_req  = 1'b0;
                ram.ram_addr = 16'h0000;
            end
        endcase
    end

    // Sample the CRTC character into the fetch stage on every CLKEN
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            f_addr_q <= 15'h0000;
            f_de_q   <= 1'b0;
            f_hs_q   <= 1'b0;
            f_vs_q   <= 1'b0;
        end else if (clken_i) begin
            f_addr_q <= {ma_i[13:12], ra_i[2:0], ma_i[9:0]};
            f_de_q   <= de_i;
            f_hs_q   <= hsync_i;
            f_vs_q   <= vsync_i;
        end
    end

    // Latch the screen mode on a rising edge of the sampled CRTC HSYNC
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            mode_lat_q <= 2'd0;
        end else if (clken_i && hsync_i && !f_hs_q) begin
            mode_lat_q <= mode_i;
        end
    end

    // Capture acknowledged bytes; a new window starts with both cleared
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            fb0_q <= 8'h00;
            fb1_q <= 8'h00;
        end else if (clken_i) begin
            fb0_q <= 8'h00;
            fb1_q <= 8'h00;
        end else if (state_q == S_REQ0 && ram.ram_ack) begin
            fb0_q <= ram.ram_data;
        end else if (state_q == S_REQ1 && ram.ram_ack) begin
            fb1_q <= ram.ram_data;
        end
    end

    // Bytes for the display load; a same-cycle ack is bypassed, missing bytes read as 0
    always_comb begin
        ld_b0    = fb0_q;
        ld_b1    = fb1_q;
        win_late = 1'b0;
        case (state_q)
            S_REQ0: begin
                ld_b0    = ram.ram_ack ? ram.ram_data : 8'h00;
                ld_b1    = 8'h00;
                win_late = 1'b1;
            end
            S_REQ1: begin
                ld_b1    = ram.ram_ack ? ram.ram_data : 8'h00;
                win_late = 1'b1;
            end
            default: begin
                ld_b0    = fb0_q;
                ld_b1    = fb1_q;
                win_late = 1'b0;
            end
        endcase
    end

    // Sticky late-fetch flag
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            late_q <= 1'b0;
        end else if (clken_i && win_late) begin
            late_q <= 1'b1;
        end
    end

    // A pixel ends every 1, 2 or 4 clocks depending on the latched mode
    always_comb begin
        case (d_mode_q)
            2'd2:    pix_end = 1'b1;
            2'd1:    pix_end = phase_q[0];
            default: pix_end = &phase_q[1:0];
        endcase
    end

    // Display stage: load on CLKEN, then shift within a byte and step to the next byte every 8 clocks.
    // DE resets to 1 so the idle output is pen 0 without the border flag.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            sr_q     <= 16'h0000;
            phase_q  <= 4'd0;
            d_mode_q <= 2'd0;
            d_de_q   <= 1'b1;
            d_hs_q   <= 1'b0;
            d_vs_q   <= 1'b0;
        end else if (clken_i) begin
            sr_q     <= {ld_b0, ld_b1};
            phase_q  <= 4'd0;
            d_mode_q <= mode_lat_q;
            d_de_q   <= f_de_q;
            d_hs_q   <= f_hs_q;
            d_vs_q   <= f_vs_q;
        end else begin
            phase_q <= phase_q + 4'd1;
            if (&phase_q[2:0]) begin
                sr_q <= {sr_q[7:0], 8'h00};
            end else if (pix_end) begin
                sr_q[15:8] <= {sr_q[14:8], 1'b0};
            end
        end
    end

    // Pen decode of the current byte, forced to border when DE is low
    always_comb begin
        pix_byte     = sr_q[15:8];
        pix_border_o = 1'b0;
        case (d_mode_q)
            2'd2:    pix_idx_o = {3'b000, pix_byte[7]};
            2'd0:    pix_idx_o = {pix_byte[1], pix_byte[5], pix_byte[3], pix_byte[7]};
            default: pix_idx_o = {2'b00, pix_byte[3], pix_byte[7]};
        endcase
        if (!d_de_q) begin
            pix_idx_o    = 4'h0;
            pix_border_o = 1'b1;
        end
    end

    // Sync shaping evaluated at each display load
    always_comb begin
        hs_run_d   = hs_run_q;
        hs_out_d   = hs_out_q;
        vs_out_d   = vs_out_q;
        vs_falls_d = vs_falls_q;
        if (clken_i) begin
            if (!f_hs_q) begin
                hs_run_d = 3'd0;
                hs_out_d = 1'b0;
            end else begin
                if (hs_run_q != 3'd7) begin
                    hs_run_d = hs_run_q + 3'd1;
                end
                hs_out_d = (hs_run_d >= 3'd3) && (hs_run_d <= 3'd6);
            end
            if (!f_vs_q) begin
                vs_out_d = 1'b0;
            end else if (!d_vs_q) begin
                vs_out_d   = 1'b1;
                vs_falls_d = 2'd0;
            end else if (vs_out_q && d_hs_q && !f_hs_q) begin
                vs_falls_d = vs_falls_q + 2'd1;
                if (vs_falls_q == 2'd1) begin
                    vs_out_d = 1'b0;
                end
            end
        end
    end

    // Sync shaping registers
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            hs_run_q   <= 3'd0;
            hs_out_q   <= 1'b0;
            vs_out_q   <= 1'b0;
            vs_falls_q <= 2'd0;
        end else begin
            hs_run_q   <= hs_run_d;
            hs_out_q   <= hs_out_d;
            vs_out_q   <= vs_out_d;
            vs_falls_q <= vs_falls_d;
        end
    end

    assign hs_out_o = hs_out_q;
    assign vs_out_o = vs_out_q;
    assign late_o   = late_q;

endmodule

// File: tb/tb_cpc_video_fetch.sv
// tb/tb_cpc_video_fetch.sv - randomized scoreboard bench for cpc_video_fetch
module tb_cpc_video_fetch;

    localparam int NCH  = 300;
    localparam int LINE = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clken;
    logic [13:0] ma;
    logic [4:0]  ra;
    logic        de, hs, vs;
    logic [1:0]  mode;
    logic [3:0]  pix;
    logic        border, hs_o, vs_o, late;

    cpc_video_fetch_if bus();

    cpc_video_fetch dut (
        .clock_i      (clk),
        .reset_i      (rst),
        .clken_i      (clken),
        .ma_i         (ma),
        .ra_i         (ra),
        .de_i         (de),
        .hsync_i      (hs),
        .vsync_i      (vs),
        .mode_i       (mode),
        .ram          (bus.master),
        .pix_idx_o    (pix),
        .pix_border_o (border),
        .hs_out_o     (hs_o),
        .vs_out_o     (vs_o),
        .late_o       (late)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;

    logic [7:0] mem [0:65535];
    logic [7:0] exp_q [$];
    logic [7:0] mon_e, mon_a;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // pen index straight from the decode rules: u is the clock offset inside the byte
    function automatic logic [3:0] pen(input logic [1:0] m, input logic [7:0] b, input int u);
        int p;
        case (m)
            2'd2: return {3'b000, b[7-u]};
            2'd1: begin p = u / 2; return {2'b00, b[3-p], b[7-p]}; end
            2'd0: begin p = u / 4; return {b[1-p], b[5-p], b[3-p], b[7-p]}; end
            default: begin p = u / 4; return {2'b00, b[3-p], b[7-p]}; end
        endcase
    endfunction

    // monitor: one expected display sample per clock once a character is loaded
    always @(posedge clk) begin
        #2;
        if (mon_en && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = {late, vs_o, hs_o, border, pix};
            n_cmp++;
            if (mon_a !== mon_e) begin
                n_bad++;
                $display("FAIL pixel at %0t: got late=%b vs=%b hs=%b border=%b pix=%h expected late=%b vs=%b hs=%b border=%b pix=%h",
                         $time, mon_a[7], mon_a[6], mon_a[5], mon_a[4], mon_a[3:0],
                         mon_e[7], mon_e[6], mon_e[5], mon_e[4], mon_e[3:0]);
            end
        end
    end

    // reference model state
    logic [14:0] cur_fa;
    logic        p_de, p_hs, p_vs;
    logic [1:0]  model_mode, disp_mode;
    bit   [1:0]  got, early;
    logic [7:0]  val [2];
    logic        nb, sel;
    int          lat, wtype, left, l_next, chars, hs_run, vs_falls, hlen, c, l;
    bit          first_window, late_m, vs_on, prev_vs_load, prev_hs_load, vlong, is_clk;
    bit          hs_e, vs_e;
    logic [7:0]  b0, b1, bb;
    logic [3:0]  pe;
    logic        n_de, n_hs, n_vs;
    logic [13:0] n_ma;
    logic [4:0]  n_ra;
    logic [1:0]  n_mode;
    bit          found;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        rst = 1'b1; clken = 1'b0; ma = '0; ra = '0; de = 1'b0; hs = 1'b0; vs = 1'b0; mode = 2'd0;
        bus.ram_ack = 1'b0; bus.ram_data = 8'h00;
        repeat (3) @(negedge clk);
        @(posedge clk); #2;
        check("reset ram_req", bus.ram_req, 0);
        check("reset late", late, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #2;
        check("post-reset ram_req", bus.ram_req, 0);
        check("post-reset ram_addr", bus.ram_addr, 0);
        check("post-reset outputs", {late, vs_o, hs_o, border, pix}, 0);

        mon_en = 1'b1;
        cur_fa = '0; p_de = 0; p_hs = 0; p_vs = 0; model_mode = 0;
        got = 0; early = 0; nb = 0; lat = 0; wtype = 0; left = 2; chars = 0;
        hs_run = 0; vs_falls = 0; first_window = 1; late_m = 0; vs_on = 0;
        prev_vs_load = 0; prev_hs_load = 0; vlong = 0; hlen = 3;

        while (chars < NCH) begin
            @(negedge clk);
            is_clk = (left == 0);
            // RAM responder
            bus.ram_ack = 1'b0;
            if (bus.ram_req) begin
                if (lat == 0) begin
                    sel = bus.ram_addr[0];
                    check("ram_addr", bus.ram_addr, {cur_fa, nb});
                    bus.ram_ack  = 1'b1;
                    bus.ram_data = mem[bus.ram_addr];
                    got[sel]   = 1'b1;
                    val[sel]   = mem[bus.ram_addr];
                    early[sel] = !is_clk;
                    nb = 1'b1;
                    if (sel == 1'b0 && wtype == 2) lat = 40;
                    else if (sel == 1'b0 && wtype == 3) lat = 13;
                    else lat = $urandom_range(0, 4);
                end else begin
                    lat--;
                end
            end
            if (is_clk) begin
                clken = 1'b1;
                // load of the character fetched in the window now closing
                b0 = got[0] ? val[0] : 8'h00;
                b1 = got[1] ? val[1] : 8'h00;
                if (!first_window && !(got[1] && early[1])) late_m = 1'b1;
                first_window = 1'b0;
                if (p_hs) hs_run++; else hs_run = 0;
                hs_e = p_hs && hs_run >= 3 && hs_run <= 6;
                if (!p_vs) vs_on = 1'b0;
                else if (!prev_vs_load) begin vs_on = 1'b1; vs_falls = 0; end
                else if (vs_on && prev_hs_load && !p_hs) begin
                    vs_falls++;
                    if (vs_falls >= 2) vs_on = 1'b0;
                end
                vs_e = vs_on;
                prev_vs_load = p_vs; prev_hs_load = p_hs;
                disp_mode = model_mode;
                l_next = ($urandom_range(0, 7) == 0) ? $urandom_range(6, 15) : 16;
                for (int t = 0; t < l_next; t++) begin
                    bb = (t < 8) ? b0 : b1;
                    pe = p_de ? pen(disp_mode, bb, t % 8) : 4'h0;
                    exp_q.push_back({late_m, vs_e, hs_e, !p_de, pe});
                end
                // next character from the CRTC
                c = chars % LINE;
                l = chars / LINE;
                if (c == 0) begin
                    hlen = $urandom_range(1, 7);
                    if (l % 5 == 0) vlong = $urandom_range(0, 1);
                end
                n_hs   = (c >= 5) && (c < 5 + hlen);
                n_vs   = (l % 5 == 2) || (vlong && l % 5 == 3);
                n_de   = (c < 5) && ($urandom_range(0, 9) != 0);
                n_ma   = 14'($urandom);
                n_ra   = 5'($urandom);
                n_mode = 2'($urandom);
                if (n_hs && !p_hs) model_mode = n_mode;
                ma = n_ma; ra = n_ra; de = n_de; hs = n_hs; vs = n_vs; mode = n_mode;
                p_de = n_de; p_hs = n_hs; p_vs = n_vs;
                cur_fa = {n_ma[13:12], n_ra[2:0], n_ma[9:0]};
                got = 0; early = 0; nb = 1'b0;
                wtype = $urandom_range(0, 9);
                if (wtype > 3) wtype = 0;
                lat = (wtype == 1) ? 40 : (wtype == 3) ? 0 : $urandom_range(0, 4);
                chars++;
                left = l_next - 1;
            end else begin
                clken = 1'b0;
                left--;
            end
        end

        @(negedge clk);
        clken = 1'b0; bus.ram_ack = 1'b0;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(negedge clk);
        check("scoreboard drained", exp_q.size(), 0);
        check("monitor sample count", (n_cmp > 3000), 1);

        // reset while the second byte is being requested
        mon_en = 1'b0;
        exp_q.delete();
        @(negedge clk);
        clken = 1'b1; ma = 14'h2ABC; ra = 5'd5; de = 1'b1;
        @(negedge clk);
        clken = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.ram_req && bus.ram_addr[0]) begin
                found = 1'b1;
                bus.ram_ack = 1'b0;
                rst = 1'b1;
                break;
            end
            bus.ram_ack  = bus.ram_req;
            bus.ram_data = 8'h11;
        end
        check("reached REQ1 before reset", found, 1);
        check("REQ1 address", bus.ram_addr, {2'b10, 3'd5, 10'h2BC, 1'b1});
        @(posedge clk); #2;
        check("ram_req after reset", bus.ram_req, 0);
        @(negedge clk);
        rst = 1'b0; bus.ram_ack = 1'b1; bus.ram_data = 8'hFF;
        @(posedge clk); #2;
        check("ram_req with stray ack", bus.ram_req, 0);
        check("outputs after reset", {late, vs_o, hs_o, border, pix}, 0);
        @(negedge clk);
        bus.ram_ack = 1'b0;
        @(posedge clk); #2;
        check("still idle after reset", {bus.ram_req, late}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
